barrel_shift_sequencer_4_bit: RTL and testbench

Registered, handshaked sequencer that sits directly upstream of the 4-bit barrel shifter datapath and also captures its result. It accepts shift requests with amounts 0..7 and breaks each request into passes of at most 3 bits, which is the per-pass limit of the 2-bit-length shifter. It feeds the shifter (enable tied high) once per clock, holds the intermediate data and carry in registers, and presents the final result with Zero and Carry flags on a valid/ready output. The shifter is either instantiated inside the block or replicated as equivalent combinational logic.

---
 rtl/barrel_shift_sequencer_4_bit_if.sv | 60 ++++++
 rtl/barrel_shift_sequencer_4_bit.sv | 157 +++++++++++++++
 tb/tb_barrel_shift_sequencer_4_bit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shift_sequencer_4_bit_if.sv
// Handshake and data bundle for the 4-bit barrel shift sequencer.
//
// Handshake rules (both sides):
//   Request side : a request transfers on the rising clock edge where
//                  Valid_In and Ready_Out are both 1. Request fields are
//                  only looked at on that edge.
//   Result side  : a result transfers on the rising clock edge where
//                  Valid_Out and Ready_In are both 1. Once Valid_Out rises,
//                  the result fields stay constant until that transfer.
// State_Dbg mirrors the sequencer FSM state (0 IDLE, 1 BUSY, 2 DONE).
`timescale 1ns/1ps
interface barrel_shift_sequencer_4_bit_if;
    logic       Valid_In;
    logic       Ready_Out;
    logic [2:0] Shift_Operation_In;
    logic [2:0] Shift_Amount_In;
    logic       Carry_In;
    logic [3:0] Data_In;
    logic       Valid_Out;
    logic       Ready_In;
    logic [3:0] Shifted_Data_Out;
    logic       Carry_Out;
    logic       Zero_Out;
    logic       Busy_Out;
    logic [1:0] State_Dbg;

    // Sequencer side
    modport slave (
        input  Valid_In,
        input  Shift_Operation_In,
        input  Shift_Amount_In,
        input  Carry_In,
        input  Data_In,
        input  Ready_In,
        output Ready_Out,
        output Valid_Out,
        output Shifted_Data_Out,
        output Carry_Out,
        output Zero_Out,
        output Busy_Out,
        output State_Dbg
    );

    // Requester / result consumer side
    modport master (
        output Valid_In,
        output Shift_Operation_In,
        output Shift_Amount_In,
        output Carry_In,
        output Data_In,
        output Ready_In,
        input  Ready_Out,
        input  Valid_Out,
        input  Shifted_Data_Out,
        input  Carry_Out,
        input  Zero_Out,
        input  Busy_Out,
        input  State_Dbg
    );
endinterface

// File: rtl/barrel_shift_sequencer_4_bit.sv
// Multi-pass sequencer around a 4-bit barrel shifter whose length input is
// only 2 bits wide. A request of 0..7 bits is split into passes of at most
// MAX_PASS_BITS bits; the working {carry,data} is held in registers between
// passes and the final result is presented on a valid/ready output.
`timescale 1ns/1ps
module barrel_shift_sequencer_4_bit #(
    parameter int MAX_PASS_BITS = 3
) (
    input  logic                          Clock_In,
    input  logic                          Reset_In,
    barrel_shift_sequencer_4_bit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASL = 3'd2;
    localparam logic [2:0] OP_ASR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;
    localparam logic [2:0] OP_RLC = 3'd6;
    localparam logic [2:0] OP_RRC = 3'd7;

    localparam logic [2:0] LP_MAX_PASS = 3'(MAX_PASS_BITS);

    // One pass of the shifter (enable permanently high). Returns {carry,data}.
    // Rotates read a window out of a doubled copy of the operand so that the
    // bits leaving one end reappear at the other. Only RLC/RRC touch carry;
    // every other op passes the (already cleared) carry through unchanged.
    function automatic logic [4:0] f_shift_pass(
        input logic [2:0] i_op,
        input logic       i_c,
        input logic [3:0] i_d,
        input logic [2:0] i_len
    );
        logic        [7:0] w_dd;
        logic        [9:0] w_cc;
        logic signed [3:0] w_sra;
        logic        [4:0] w_res;
        w_dd  = {i_d, i_d};
        w_cc  = {i_c, i_d, i_c, i_d};
        w_sra = $signed(i_d) >>> i_len;
        w_res = {i_c, i_d};
        case (i_op)
            OP_LSL, OP_ASL: w_res = {i_c, i_d << i_len};
            OP_LSR:         w_res = {i_c, i_d >> i_len};
            OP_ASR:         w_res = {i_c, w_sra};
            OP_ROL:         w_res = {i_c, w_dd[3'd7 - i_len -: 4]};
            OP_ROR:         w_res = {i_c, w_dd[3'd3 + i_len -: 4]};
            OP_RLC:         w_res = w_cc[4'd9 - 4'(i_len) -: 5];
            OP_RRC:         w_res = w_cc[4'd4 + 4'(i_len) -: 5];
            default:        w_res = {i_c, i_d};
        endcase
        return w_res;
    endfunction

    state_t     r_state;
    logic [2:0] r_op;
    logic [3:0] r_data;
    logic       r_carry;
    logic [2:0] r_rem;
    logic       r_ready;
    logic       r_valid;
    logic       r_busy;
    logic [3:0] r_out_data;
    logic       r_out_carry;
    logic       r_zero;

    logic [2:0] w_pass_len;
    logic [2:0] w_rem_next;
    logic [4:0] w_pass_res;
    logic       w_carry_op;

    // Pass length is the remaining amount clipped to the shifter's reach.
    assign w_pass_len = (r_rem > LP_MAX_PASS) ? LP_MAX_PASS : r_rem;
    assign w_rem_next = r_rem - w_pass_len;
    assign w_pass_res = f_shift_pass(r_op, r_carry, r_data, w_pass_len);
    assign w_carry_op = (bus.Shift_Operation_In == OP_RLC) ||
                        (bus.Shift_Operation_In == OP_RRC);

    // Sequencer FSM: accept in IDLE, one shifter pass per clock in BUSY,
    // hold the registered result in DONE until the consumer takes it.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state     <= ST_IDLE;
            r_op        <= 3'd0;
            r_data      <= 4'd0;
            r_carry     <= 1'b0;
            r_rem       <= 3'd0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= 4'd0;
            r_out_carry <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Valid_In) begin
                        r_op    <= bus.Shift_Operation_In;
                        r_data  <= bus.Data_In;
                        // Carry only participates in the through-carry rotates.
                        r_carry <= w_carry_op ? bus.Carry_In : 1'b0;
                        r_rem   <= bus.Shift_Amount_In;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An amount of 0 still runs one zero-length pass here.
                    r_data  <= w_pass_res[3:0];
                    r_carry <= w_pass_res[4];
                    r_rem   <= w_rem_next;
                    if (w_rem_next == 3'd0) begin
                        r_out_data  <= w_pass_res[3:0];
                        r_out_carry <= w_pass_res[4];
                        r_zero      <= (w_pass_res[3:0] == 4'd0);
                        r_valid     <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.Ready_In) begin
                        r_out_data  <= 4'd0;
                        r_out_carry <= 1'b0;
                        r_zero      <= 1'b0;
                        r_valid     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Ready_Out        = r_ready;
    assign bus.Valid_Out        = r_valid;
    assign bus.Shifted_Data_Out = r_out_data;
    assign bus.Carry_Out        = r_out_carry;
    assign bus.Zero_Out         = r_zero;
    assign bus.Busy_Out         = r_busy;
    assign bus.State_Dbg        = r_state;

endmodule

// File: tb/tb_barrel_shift_sequencer_4_bit.sv
// Bench for barrel_shift_sequencer_4_bit: directed requests with
// hand-computed results, an expected queue filled by the driver and a
// monitor that checks latency and result on every output handshake.
`timescale 1ns/1ps
module tb_barrel_shift_sequencer_4_bit;

  localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ASL = 3'd2, ASR = 3'd3;
  localparam logic [2:0] ROL = 3'd4, ROR = 3'd5, RLC = 3'd6, RRC = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  bit   seen_valid = 1'b0;

  // Expected entry: {passes[1:0], carry, data[3:0]}
  logic [6:0] exp_q[$];

  barrel_shift_sequencer_4_bit_if bus();

  barrel_shift_sequencer_4_bit dut (
    .Clock_In (clk),
    .Reset_In (rst),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] amt, input logic cin,
                      input logic [3:0] d, input logic [3:0] ed, input logic ec,
                      input logic [1:0] passes, input bit push);
    int n = 0;
    while (!bus.Ready_Out && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.Ready_Out) begin
      tests++; fails++;
      $display("FAIL send_timeout: Ready_Out=%0b expected 1", bus.Ready_Out);
      return;
    end
    bus.Valid_In           = 1'b1;
    bus.Shift_Operation_In = op;
    bus.Shift_Amount_In    = amt;
    bus.Carry_In           = cin;
    bus.Data_In            = d;
    if (push) exp_q.push_back({passes, ec, ed});
    @(posedge clk); #1;
    bus.Valid_In = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [6:0] e;
    if (rst) begin
      seen_valid = 1'b0;
    end else begin
      if (bus.Valid_In && bus.Ready_Out) acc_edge = cyc + 1;
      if (!bus.Valid_Out) check("zero_when_invalid", 8'(bus.Zero_Out), 8'd0);
      if (bus.Valid_Out && !seen_valid) begin
        seen_valid = 1'b1;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: Valid_Out=1 expected 0 (no request pending)");
        end else begin
          e = exp_q[0];
          check("latency", 8'(cyc - acc_edge), 8'(e[6:5]));
        end
      end
      if (bus.Valid_Out && bus.Ready_In) begin
        seen_valid = 1'b0;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data",  8'(bus.Shifted_Data_Out), 8'(e[3:0]));
          check("carry", 8'(bus.Carry_Out),        8'(e[4]));
          check("zero",  8'(bus.Zero_Out),         8'(e[3:0] == 4'd0));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.Valid_In           = 1'b0;
    bus.Shift_Operation_In = 3'd0;
    bus.Shift_Amount_In    = 3'd0;
    bus.Carry_In           = 1'b0;
    bus.Data_In            = 4'd0;
    bus.Ready_In           = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 8'(bus.Ready_Out),        8'd1);
    check("rst_valid", 8'(bus.Valid_Out),        8'd0);
    check("rst_busy",  8'(bus.Busy_Out),         8'd0);
    check("rst_data",  8'(bus.Shifted_Data_Out), 8'd0);
    check("rst_carry", 8'(bus.Carry_Out),        8'd0);
    check("rst_zero",  8'(bus.Zero_Out),         8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // op, amt, cin, data, exp data, exp carry, passes
    send(LSL, 3'd2, 1'b0, 4'b1011, 4'b1100, 1'b0, 2'd1, 1'b1); drain();
    send(ASR, 3'd7, 1'b0, 4'b1001, 4'b1111, 1'b0, 2'd3, 1'b1); drain();
    send(ROR, 3'd5, 1'b0, 4'b0001, 4'b1000, 1'b0, 2'd2, 1'b1); drain();
    send(LSR, 3'd4, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd2, 1'b1); drain();
    send(RLC, 3'd6, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd2, 1'b1); drain();
    send(RRC, 3'd1, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd1, 1'b1); drain();
    send(ASL, 3'd3, 1'b0, 4'b0011, 4'b1000, 1'b0, 2'd1, 1'b1); drain();
    send(LSL, 3'd7, 1'b0, 4'b0111, 4'b0000, 1'b0, 2'd3, 1'b1); drain();
    send(ASR, 3'd5, 1'b0, 4'b0110, 4'b0000, 1'b0, 2'd2, 1'b1); drain();
    send(ROL, 3'd6, 1'b0, 4'b1001, 4'b0110, 1'b0, 2'd2, 1'b1); drain();
    send(RLC, 3'd7, 1'b1, 4'b0101, 4'b0110, 1'b1, 2'd3, 1'b1); drain();
    send(RRC, 3'd4, 1'b1, 4'b0110, 4'b1101, 1'b0, 2'd2, 1'b1); drain();
    send(LSL, 3'd1, 1'b1, 4'b0001, 4'b0010, 1'b0, 2'd1, 1'b1); drain();
    send(ROL, 3'd4, 1'b0, 4'b1011, 4'b1011, 1'b0, 2'd2, 1'b1); drain();
    send(ROR, 3'd0, 1'b0, 4'b1010, 4'b1010, 1'b0, 2'd1, 1'b1); drain();
    send(RLC, 3'd0, 1'b1, 4'b0011, 4'b0011, 1'b1, 2'd1, 1'b1); drain();
    send(ASR, 3'd3, 1'b1, 4'b1000, 4'b1111, 1'b0, 2'd1, 1'b1); drain();

    // Backpressure: result must hold and new requests must be ignored.
    bus.Ready_In = 1'b0;
    send(ROL, 3'd1, 1'b0, 4'b0011, 4'b0110, 1'b0, 2'd1, 1'b1);
    n = 0;
    while (!bus.Valid_Out && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("bp_valid_seen", 8'(bus.Valid_Out), 8'd1);
    for (int i = 0; i < 3; i++) begin
      bus.Valid_In           = 1'b1;
      bus.Shift_Operation_In = LSR;
      bus.Shift_Amount_In    = 3'd3;
      bus.Data_In            = 4'b1111;
      @(negedge clk);
      check("bp_valid_hold", 8'(bus.Valid_Out),        8'd1);
      check("bp_data_hold",  8'(bus.Shifted_Data_Out), 8'b0110);
      check("bp_ready_low",  8'(bus.Ready_Out),        8'd0);
      check("bp_busy_high",  8'(bus.Busy_Out),         8'd1);
      @(posedge clk); #1;
    end
    bus.Valid_In = 1'b0;
    bus.Ready_In = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 8'(bus.Valid_Out), 8'd0);
    check("bp_release_ready", 8'(bus.Ready_Out), 8'd1);
    check("bp_release_busy",  8'(bus.Busy_Out),  8'd0);
    drain();

    // Reset during BUSY of an amount-7 ASR aborts without a result.
    send(ASR, 3'd7, 1'b0, 4'b1001, 4'b1111, 1'b0, 2'd3, 1'b0);
    check("abort_busy_before",  8'(bus.Busy_Out),  8'd1);
    check("abort_ready_before", 8'(bus.Ready_Out), 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_valid", 8'(bus.Valid_Out),        8'd0);
    check("abort_busy",  8'(bus.Busy_Out),         8'd0);
    check("abort_ready", 8'(bus.Ready_Out),        8'd1);
    check("abort_data",  8'(bus.Shifted_Data_Out), 8'd0);
    check("abort_carry", 8'(bus.Carry_Out),        8'd0);
    check("abort_zero",  8'(bus.Zero_Out),         8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(ASR, 3'd7, 1'b0, 4'b1001, 4'b1111, 1'b0, 2'd3, 1'b1); drain();
    send(RRC, 3'd2, 1'b1, 4'b0000, 4'b0100, 1'b0, 2'd1, 1'b1); drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
